// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for a Galois LFSR word stream: seeds from received
// words while hunting, then free-runs its own prediction and counts mismatches once locked.
module lfsr_stream_checker #(
  parameter int WIDTH           = 8,
  parameter int TAP_INDEX_WIDTH = 12,
  parameter int TAP_COUNT       = 4,
  parameter int LOCK_COUNT      = 4,
  parameter int UNLOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_clear,
  input  logic [TAP_COUNT*TAP_INDEX_WIDTH-1:0] i_taps,
  input  logic                                 i_valid,
  input  logic [WIDTH-1:0]                     i_data,
  output logic                                 o_locked,
  output logic                                 o_err_pulse,
  output logic [ERR_CNT_WIDTH-1:0]             o_err_count,
  output logic [ERR_CNT_WIDTH-1:0]             o_word_count,
  output logic [WIDTH-1:0]                     o_expected
);

  localparam int TIW = TAP_INDEX_WIDTH;
  localparam int CW  = ERR_CNT_WIDTH;
  localparam int RW  = $clog2(LOCK_COUNT + 1);
  localparam int BW  = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            primed_q, primed_d;
  logic [RW-1:0]   run_q, run_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic            pulse_q, pulse_d;
  logic [CW-1:0]   err_q, err_d;
  logic [CW-1:0]   word_q, word_d;

  // Tap fields overwrite (not accumulate), so duplicates are harmless and
  // out-of-range fields never match any bit position.
  function automatic logic [WIDTH-1:0] gstep(input logic [WIDTH-1:0] c,
                                             input logic [TAP_COUNT*TIW-1:0] taps);
    logic [WIDTH-1:0] n;
    logic [TIW-1:0]   t;
    n = {c[WIDTH-2:0], c[WIDTH-1]};
    for (int k = 0; k < TAP_COUNT; k++) begin
      t = taps[k*TIW +: TIW];
      for (int j = 0; j < WIDTH; j++) begin
        if (t == TIW'(j + 1)) n[j] = c[WIDTH-1] ^ c[j];
      end
    end
    return n;
  endfunction

  logic [WIDTH-1:0] step_nxt;
  logic             match;
  logic [RW-1:0]    run_inc;
  logic [BW-1:0]    bad_inc;

  // LOCKED free-runs on its own prediction so a corrupted word never reseeds it.
  assign step_nxt = gstep((state_q == LOCKED) ? exp_q : i_data, i_taps);
  assign match    = (i_data == exp_q);
  assign run_inc  = run_q + RW'(1);
  assign bad_inc  = bad_q + BW'(1);

  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    run_d    = run_q;
    bad_d    = bad_q;
    exp_d    = exp_q;
    err_d    = err_q;
    word_d   = word_q;
    pulse_d  = 1'b0;
    if (i_valid) begin
      exp_d = step_nxt;
      if (state_q == HUNT) begin
        primed_d = 1'b1;
        if (primed_q && match) begin
          if (run_inc == RW'(LOCK_COUNT)) begin
            state_d = LOCKED;
            run_d   = '0;
            bad_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
        end
      end else begin
        if (word_q != '1) word_d = word_q + CW'(1);
        if (!match) begin
          pulse_d = 1'b1;
          if (err_q != '1) err_d = err_q + CW'(1);
          if (bad_inc == BW'(UNLOCK_COUNT)) begin
            state_d  = HUNT;
            primed_d = 1'b0;
            run_d    = '0;
            bad_d    = '0;
          end else begin
            bad_d = bad_inc;
          end
        end else begin
          bad_d = '0;
        end
      end
    end
    if (i_clear) begin
      err_d  = '0;
      word_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= HUNT;
      primed_q <= 1'b0;
      run_q    <= '0;
      bad_q    <= '0;
      exp_q    <= '0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      run_q    <= run_d;
      bad_q    <= bad_d;
      exp_q    <= exp_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign o_locked     = (state_q == LOCKED);
  assign o_err_pulse  = pulse_q;
  assign o_err_count  = err_q;
  assign o_word_count = word_q;
  assign o_expected   = exp_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench: two checker instances (default counters, and 4-bit counters with
// a long unlock threshold) fed one stream and compared every cycle to a reference model.
module tb_lfsr_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = '0;
  logic [47:0] taps = '0;

  logic        a_locked, a_pulse, b_locked, b_pulse;
  logic [15:0] a_ec, a_wc;
  logic [3:0]  b_ec, b_wc;
  logic [7:0]  a_exp, b_exp;

  always #5 clk = ~clk;

  lfsr_stream_checker dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_taps(taps), .i_valid(valid),
    .i_data(data), .o_locked(a_locked), .o_err_pulse(a_pulse), .o_err_count(a_ec),
    .o_word_count(a_wc), .o_expected(a_exp));

  lfsr_stream_checker #(.ERR_CNT_WIDTH(4), .UNLOCK_COUNT(32)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_taps(taps), .i_valid(valid),
    .i_data(data), .o_locked(b_locked), .o_err_pulse(b_pulse), .o_err_count(b_ec),
    .o_word_count(b_wc), .o_expected(b_exp));

  typedef struct {
    bit locked; bit primed; int run; int bad; int expv; int ec; int wc; bit pulse;
  } mst_t;

  mst_t ma, mb;
  mst_t qa[$], qb[$];
  int   errors = 0, checks = 0;
  int   g;

  function automatic int gal(int c, logic [47:0] tp);
    int msb, n;
    msb = (c >> 7) & 1;
    n   = ((c << 1) & 255) | msb;
    for (int k = 0; k < 4; k++) begin
      int t, b;
      t = int'(tp[k*12 +: 12]);
      if (t >= 1 && t <= 8) begin
        b = ((c >> (t - 1)) & 1) ^ msb;
        n = (n & ~(1 << (t - 1))) | (b << (t - 1));
      end
    end
    return n;
  endfunction

  function automatic mst_t mstep(mst_t s, bit rn, bit cl, bit v, int d, logic [47:0] tp,
                                 int unl, int cmax);
    mst_t r;
    bit   m;
    r = s;
    r.pulse = 0;
    if (!rn) begin
      r = '{default: 0};
      return r;
    end
    if (v) begin
      m = (d == s.expv);
      if (!s.locked) begin
        r.run    = (s.primed && m) ? s.run + 1 : 0;
        r.expv   = gal(d, tp);
        r.primed = 1;
        if (s.primed && m && r.run == 4) begin
          r.locked = 1; r.run = 0; r.bad = 0;
        end
      end else begin
        r.expv = gal(s.expv, tp);
        if (s.wc < cmax) r.wc = s.wc + 1;
        if (!m) begin
          r.pulse = 1;
          if (s.ec < cmax) r.ec = s.ec + 1;
          r.bad = s.bad + 1;
        end else begin
          r.bad = 0;
        end
        if (r.bad == unl) begin
          r.locked = 0; r.primed = 0; r.run = 0; r.bad = 0;
        end
      end
    end
    if (cl) begin
      r.ec = 0; r.wc = 0;
    end
    return r;
  endfunction

  task automatic cyc(input bit rn, input bit cl, input bit v, input int d);
    @(posedge clk);
    #2;
    rst_n = rn; clear = cl; valid = v; data = d[7:0];
    ma = mstep(ma, rn, cl, v, d & 255, taps, 4, 65535);
    mb = mstep(mb, rn, cl, v, d & 255, taps, 32, 15);
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  task automatic clean(input int n);
    repeat (n) begin cyc(1, 0, 1, g); g = gal(g, taps); end
  endtask

  task automatic badr(input int n);
    repeat (n) begin cyc(1, 0, 1, g ^ int'($urandom_range(1, 255))); g = gal(g, taps); end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    mst_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_locked", int'(a_locked), int'(e.locked));
        chk("a_err_pulse", int'(a_pulse), int'(e.pulse));
        chk("a_err_count", int'(a_ec), e.ec);
        chk("a_word_count", int'(a_wc), e.wc);
        chk("a_expected", int'(a_exp), e.expv);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_locked", int'(b_locked), int'(e.locked));
        chk("b_err_pulse", int'(b_pulse), int'(e.pulse));
        chk("b_err_count", int'(b_ec), e.ec);
        chk("b_word_count", int'(b_wc), e.wc);
        chk("b_expected", int'(b_exp), e.expv);
      end
    end
  end

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    taps = {12'd8, 12'd6, 12'd5, 12'd4};
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 8'h5A);
    // lock acquisition from seed 0xFF
    g = 8'hFF;
    clean(12);
    // single bit-0 flip while locked
    cyc(1, 0, 1, g ^ 1); g = gal(g, taps);
    clean(6);
    // four corrupted words, then relock
    badr(4);
    clean(10);
    // long error burst: saturates the 4-bit counters
    badr(20);
    clean(8);
    // clear coinciding with an error word
    cyc(1, 1, 1, g ^ 8'h10); g = gal(g, taps);
    clean(4);
    // gapped stream, reset while locked, gapped relock
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) clean(1);
      else begin cyc(1, 0, 0, int'($urandom)); end
    end
    cyc(0, 0, 1, g); g = gal(g, taps);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) clean(1);
      else begin cyc(1, 0, 0, int'($urandom)); end
    end
    // all-zero stream locks with any taps
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0);
    // randomized mix, taps changed midway (including ignored field values)
    g = 8'h01;
    for (int i = 0; i < 500; i++) begin
      int r;
      if (i == 250) taps = {12'($urandom_range(0, 10)), 12'($urandom_range(0, 10)),
                            12'd8, 12'($urandom_range(0, 10))};
      r = int'($urandom_range(0, 199));
      if (r == 0) begin cyc(0, 0, 0, 0); end
      else if (r < 5) begin cyc(1, 1, 1, g); g = gal(g, taps); end
      else if (r < 15) badr(1);
      else if (r < 60) begin cyc(1, 0, 0, int'($urandom)); end
      else clean(1);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
